mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and synchronous active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_op  in  4  NONE/LB/LBU/LH/LHU/LW/SB/SH/SW, from EX/MEM register.
REQ-005 mem_addr, mem_store_data  in  32 each  effective address; store source.
REQ-006 result_in, write_reg_en_in, write_reg_addr_in  in  32/1/5  EX result and write-back info.
REQ-007 write_hilo_en_in, write_hi_data_in, write_lo_data_in  in  1/32/32  HI/LO write info.
REQ-008 ram_req, ram_we  out  1 each  bus request; write strobe.
REQ-009 ram_sel  out  4  byte-lane enables.
REQ-010 ram_addr, ram_wdata  out  32 each  word address; write data.
REQ-011 ram_rdata, ram_ack  in  32/1  read data; completion, sampled at rising edge.
REQ-012 mem_stall_request  out  1  freezes PC..EX/MEM.
REQ-013 addr_error  out  1  misaligned access flag.
REQ-014 result_out, write_reg_en_out, write_reg_addr_out  out  32/1/5  to MEM/WB.
REQ-015 write_hilo_en_out, write_hi_data_out, write_lo_data_out  out  1/32/32  to MEM/WB.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-017 mem_op=NONE in IDLE: outputs SHALL equal inputs combinationally; ram_req=0; stall=0.
REQ-018 Memory op in IDLE, aligned: SHALL drive ram_req=1 and stall=1 in the same cycle; next state DONE if ram_ack, else ACCESS.
REQ-019 ACCESS: ram_req=1, stall=1; request fields SHALL stay stable; on ram_ack go to DONE.
REQ-020 At the ack edge, ram_rdata SHALL be captured into a 32-bit register.
REQ-021 DONE: ram_req=0, stall=0; load result drives result_out; next state IDLE.
REQ-022 Minimum load/store latency SHALL be one stall cycle; no upper bound.
REQ-023 ram_addr SHALL be {mem_addr[31:2],2'b00}; lane = mem_addr[1:0], little-endian.
REQ-024 LB/LBU SHALL use lane byte, sign/zero-extended; LH/LHU SHALL use half addr[1], sign/zero-extended; LW SHALL use the full word.
REQ-025 SB: ram_sel one-hot on lane; wdata = byte replicated x4.
REQ-026 SH: ram_sel 0011/1100; wdata = half replicated x2.
REQ-027 SW: ram_sel 1111.
REQ-028 Loads: ram_we=0, ram_sel=1111.
REQ-029 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL assert addr_error in IDLE, issue no request and no stall, force write_reg_en_out=0, and force write_hilo_en_out=0.
REQ-030 Stores SHALL force write_reg_en_out=0; loads SHALL pass write_reg_en_in.
REQ-031 HI/LO fields SHALL pass through unchanged in every state except misalignment.
REQ-032 ram_ack while ram_req=0 SHALL be ignored.

Reset
REQ-033 rst SHALL force IDLE and clear the capture register at the next edge, including mid-ACCESS; the request drops that edge.
REQ-034 While rst=1, all outputs SHALL be zero: ram_req=0, stall=0, write_reg_addr_out=0, write enables=0.

Structure
REQ-035 mem_op encodings and the FSM state encoding SHALL live in the shared define files.
REQ-036 Load extension and store lane steering SHALL form one sub-module, mem_align, with no state.
REQ-037 Target size SHALL be 150-250 RTL lines.

Verification
REQ-038 ADDU pass-through (result_in=0x1234, reg 5): same-cycle result_out=0x1234, ram_req=0, stall=0.
REQ-039 LB at addr 0x103, ack on the first cycle, rdata=0x80FF_FFFF: one stall cycle, then DONE result_out=0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-040 SH at addr 0x202, data 0xABCD_5678, ack after 3 cycles: ram_sel=1100, wdata=0x5678_5678, ram_we=1, 4 stall cycles, write_reg_en_out=0.
REQ-041 LW at addr 0x101: addr_error=1, ram_req=0, stall=0, write_reg_en_out=0.
REQ-042 LW with ack withheld, rst pulsed in the second ACCESS cycle: next cycle IDLE, ram_req=0, a late ack is ignored, outputs are zero during reset.
REQ-043 MTHI in IDLE: write_hilo_en_out=1 with hi/lo data unchanged; an SW followed by LW of the same word returns the stored value.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-op and FSM encodings shared by the MEM stage.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic op_is_load(input mem_op_e op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && addr_lo[0]) ||
               ((op inside {MEM_LW, MEM_SW}) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-RAM request/ack bus between the MEM stage and memory.
interface mem_stage_if;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport master (
        output ram_req, ram_we, ram_sel, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  ram_req, ram_we, ram_sel, ram_addr, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - stateless load extension and store byte-lane steering (little-endian).
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        lane_half   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sel_o       = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        case (op_i)
            MEM_LB:  load_data_o = {{24{lane_byte[7]}}, lane_byte};
            MEM_LBU: load_data_o = {24'h0, lane_byte};
            MEM_LH:  load_data_o = {{16{lane_half[15]}}, lane_half};
            MEM_LHU: load_data_o = {16'h0, lane_half};
            MEM_SB: begin
                sel_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEM_SH: begin
                sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: issues RAM accesses, stalls until ack, aligns loads.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    input  logic [31:0] result_in,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_reg_addr_in,
    input  logic        write_hilo_en_in,
    input  logic [31:0] write_hi_data_in,
    input  logic [31:0] write_lo_data_in,
    mem_stage_if.master bus,
    output logic        mem_stall_request,
    output logic        addr_error,
    output logic [31:0] result_out,
    output logic        write_reg_en_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        write_hilo_en_out,
    output logic [31:0] write_hi_data_out,
    output logic [31:0] write_lo_data_out
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q;

    mem_op_e     op;
    logic        is_load, is_store, misaligned;
    logic [3:0]  align_sel;
    logic [31:0] align_wdata, load_data;

    assign op         = mem_op_e'(mem_op);
    assign is_load    = op_is_load(op);
    assign is_store   = op_is_store(op);
    assign misaligned = op_misaligned(op, mem_addr[1:0]);

    // Loads are extended from the captured word, so DONE sees stable data after ack drops.
    mem_align u_align (
        .op_i         (op),
        .addr_lo_i    (mem_addr[1:0]),
        .store_data_i (mem_store_data),
        .rdata_i      (rdata_q),
        .sel_o        (align_sel),
        .wdata_o      (align_wdata),
        .load_data_o  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (bus.ram_req && bus.ram_ack) begin
                rdata_q <= bus.ram_rdata;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.ram_req        = 1'b0;
        bus.ram_we         = 1'b0;
        bus.ram_sel        = is_load ? 4'b1111 : align_sel;
        bus.ram_addr       = {mem_addr[31:2], 2'b00};
        bus.ram_wdata      = align_wdata;
        mem_stall_request  = 1'b0;
        addr_error         = 1'b0;
        result_out         = result_in;
        write_reg_en_out   = write_reg_en_in & ~is_store;
        write_reg_addr_out = write_reg_addr_in;
        write_hilo_en_out  = write_hilo_en_in;
        write_hi_data_out  = write_hi_data_in;
        write_lo_data_out  = write_lo_data_in;

        case (state_q)
            ST_IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        addr_error        = 1'b1;
                        write_reg_en_out  = 1'b0;
                        write_hilo_en_out = 1'b0;
                    end else begin
                        bus.ram_req       = 1'b1;
                        mem_stall_request = 1'b1;
                        state_d           = bus.ram_ack ? ST_DONE : ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                bus.ram_req       = 1'b1;
                mem_stall_request = 1'b1;
                if (bus.ram_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (is_load) begin
                    result_out = load_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus.ram_we = bus.ram_req & is_store;

        if (rst) begin
            state_d            = ST_IDLE;
            bus.ram_req        = 1'b0;
            bus.ram_we         = 1'b0;
            bus.ram_sel        = 4'b0000;
            bus.ram_addr       = 32'h0;
            bus.ram_wdata      = 32'h0;
            mem_stall_request  = 1'b0;
            addr_error         = 1'b0;
            result_out         = 32'h0;
            write_reg_en_out   = 1'b0;
            write_reg_addr_out = 5'd0;
            write_hilo_en_out  = 1'b0;
            write_hi_data_out  = 32'h0;
            write_lo_data_out  = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_store_data, result_in;
    logic        write_reg_en_in, write_hilo_en_in;
    logic [4:0]  write_reg_addr_in;
    logic [31:0] write_hi_data_in, write_lo_data_in;
    logic        mem_stall_request, addr_error;
    logic [31:0] result_out;
    logic        write_reg_en_out, write_hilo_en_out;
    logic [4:0]  write_reg_addr_out;
    logic [31:0] write_hi_data_out, write_lo_data_out;

    int checks = 0;
    int errors = 0;
    int stalls;
    logic [3:0]  sel0;
    logic [31:0] wdata0, addr0, mem_word;
    logic        we0;

    mem_stage_if bus ();

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .mem_op             (mem_op),
        .mem_addr           (mem_addr),
        .mem_store_data     (mem_store_data),
        .result_in          (result_in),
        .write_reg_en_in    (write_reg_en_in),
        .write_reg_addr_in  (write_reg_addr_in),
        .write_hilo_en_in   (write_hilo_en_in),
        .write_hi_data_in   (write_hi_data_in),
        .write_lo_data_in   (write_lo_data_in),
        .bus                (bus),
        .mem_stall_request  (mem_stall_request),
        .addr_error         (addr_error),
        .result_out         (result_out),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out),
        .write_hilo_en_out  (write_hilo_en_out),
        .write_hi_data_out  (write_hi_data_out),
        .write_lo_data_out  (write_lo_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] res, input logic [4:0] waddr);
        @(posedge clk);
        #1;
        mem_op            = op;
        mem_addr          = addr;
        mem_store_data    = sdata;
        result_in         = res;
        write_reg_en_in   = 1'b1;
        write_reg_addr_in = waddr;
        write_hilo_en_in  = 1'b0;
    endtask

    // Ack is raised in stall cycle ack_cycle; returns at the negedge of the first non-stall cycle.
    task automatic do_access(input int ack_cycle, input logic [31:0] rdata);
        stalls = 0;
        for (int c = 0; c < 32; c++) begin
            bus.ram_ack   = (c == ack_cycle);
            bus.ram_rdata = (c == ack_cycle) ? rdata : 32'h0;
            @(negedge clk);
            if (c == 0) begin
                sel0 = bus.ram_sel; wdata0 = bus.ram_wdata; we0 = bus.ram_we; addr0 = bus.ram_addr;
            end
            if (!mem_stall_request) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        bus.ram_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_op = MEM_NONE; mem_addr = 32'h0; mem_store_data = 32'h0;
        result_in = 32'hDEAD_BEEF; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd5;
        write_hilo_en_in = 1'b1; write_hi_data_in = 32'h1111_2222; write_lo_data_in = 32'h3333_4444;
        bus.ram_ack = 1'b0; bus.ram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'h0, bus.ram_req}, 32'h0);
        check("rst_stall", {31'h0, mem_stall_request}, 32'h0);
        check("rst_result", result_out, 32'h0);
        check("rst_waddr", {27'h0, write_reg_addr_out}, 32'h0);
        check("rst_wen", {30'h0, write_reg_en_out, write_hilo_en_out}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        set_op(MEM_NONE, 32'h0, 32'h0, 32'h1234, 5'd5);
        @(negedge clk);
        check("addu_result", result_out, 32'h1234);
        check("addu_waddr", {27'h0, write_reg_addr_out}, 32'd5);
        check("addu_req_stall", {30'h0, bus.ram_req, mem_stall_request}, 32'h0);

        set_op(MEM_LB, 32'h103, 32'h0, 32'h0, 5'd7);
        do_access(0, 32'h80FF_FFFF);
        check("lb_stalls", stalls, 32'd1);
        check("lb_addr", addr0, 32'h100);
        check("lb_sel_we", {27'h0, sel0, we0}, {27'h0, 4'b1111, 1'b0});
        check("lb_result", result_out, 32'hFFFF_FF80);
        check("lb_wen", {31'h0, write_reg_en_out}, 32'h1);
        set_op(MEM_LBU, 32'h103, 32'h0, 32'h0, 5'd7);
        do_access(0, 32'h80FF_FFFF);
        check("lbu_result", result_out, 32'h0000_0080);

        set_op(MEM_LH, 32'h2, 32'h0, 32'h0, 5'd8);
        do_access(1, 32'h8001_1234);
        check("lh_stalls", stalls, 32'd2);
        check("lh_result", result_out, 32'hFFFF_8001);
        set_op(MEM_LHU, 32'h2, 32'h0, 32'h0, 5'd8);
        do_access(0, 32'h8001_1234);
        check("lhu_result", result_out, 32'h0000_8001);

        set_op(MEM_SH, 32'h202, 32'hABCD_5678, 32'h0, 5'd9);
        do_access(3, 32'h0);
        check("sh_stalls", stalls, 32'd4);
        check("sh_sel", {28'h0, sel0}, 32'hC);
        check("sh_wdata", wdata0, 32'h5678_5678);
        check("sh_we", {31'h0, we0}, 32'h1);
        check("sh_wen", {31'h0, write_reg_en_out}, 32'h0);

        set_op(MEM_SB, 32'h201, 32'h0000_00AB, 32'h0, 5'd9);
        do_access(0, 32'h0);
        check("sb_sel", {28'h0, sel0}, 32'h2);
        check("sb_wdata", wdata0, 32'hABAB_ABAB);

        set_op(MEM_LW, 32'h101, 32'h0, 32'h0, 5'd10);
        @(negedge clk);
        check("mis_err", {31'h0, addr_error}, 32'h1);
        check("mis_req_stall", {30'h0, bus.ram_req, mem_stall_request}, 32'h0);
        check("mis_wen", {31'h0, write_reg_en_out}, 32'h0);

        set_op(MEM_LW, 32'h300, 32'h0, 32'h55, 5'd11);
        bus.ram_ack = 1'b0;
        @(negedge clk);
        check("rl_idle_stall", {31'h0, mem_stall_request}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rl_access_stall", {31'h0, mem_stall_request}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rl_rst_req_stall", {30'h0, bus.ram_req, mem_stall_request}, 32'h0);
        check("rl_rst_waddr", {27'h0, write_reg_addr_out}, 32'h0);
        check("rl_rst_wen", {30'h0, write_reg_en_out, write_hilo_en_out}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_op = MEM_NONE; bus.ram_ack = 1'b1; bus.ram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rl_late_ack_req", {30'h0, bus.ram_req, mem_stall_request}, 32'h0);
        check("rl_late_ack_res", result_out, 32'h55);
        bus.ram_ack = 1'b0;
        set_op(MEM_LW, 32'h300, 32'h0, 32'h0, 5'd11);
        do_access(0, 32'h0BAD_F00D);
        check("rl_after_stalls", stalls, 32'd1);
        check("rl_after_result", result_out, 32'h0BAD_F00D);

        set_op(MEM_NONE, 32'h0, 32'h0, 32'h0, 5'd0);
        write_hilo_en_in = 1'b1; write_hi_data_in = 32'hAAAA_0001; write_lo_data_in = 32'hBBBB_0002;
        @(negedge clk);
        check("mthi_en", {31'h0, write_hilo_en_out}, 32'h1);
        check("mthi_hi", write_hi_data_out, 32'hAAAA_0001);
        check("mthi_lo", write_lo_data_out, 32'hBBBB_0002);

        mem_word = 32'h0;
        set_op(MEM_SW, 32'h400, 32'hCAFE_BABE, 32'h0, 5'd12);
        do_access(1, 32'h0);
        if (we0 && sel0 == 4'b1111) mem_word = wdata0;
        check("sw_sel", {28'h0, sel0}, 32'hF);
        check("sw_wen", {31'h0, write_reg_en_out}, 32'h0);
        set_op(MEM_LW, 32'h400, 32'h0, 32'h0, 5'd12);
        do_access(2, mem_word);
        check("sw_lw_result", result_out, 32'hCAFE_BABE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
